// File: rtl/psram_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psram_resp_pkg
// Description : Shared types and constants for the PSRAM QSPI responder:
//               FSM state encoding, command opcodes and address length.
// Revision    : 1.0 - initial release
// ============================================================================
package psram_resp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    WAIT  = 3'd3,
    RDATA = 3'd4,
    WDATA = 3'd5
  } state_t;

  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_QREAD     = 8'hEB;
  localparam logic [7:0] CMD_QWRITE    = 8'h38;
  localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
  localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;

  localparam int ADDR_BITS = 24;

endpackage : psram_resp_pkg
`default_nettype wire

// File: rtl/psram_resp_sync.sv
`default_nettype none
// ============================================================================
// Module      : psram_resp_sync
// Description : Two-flop synchronizers for sck, ce_n and io_di, plus
//               single-cycle rise/fall pulses for sck and ce_n in clk.
//               io_di has the same latency as the sck edge pulses, so the
//               data presented with a rise pulse is the data at the sck rise.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_resp_sync
  import psram_resp_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sck_i,
  input  logic       ce_n_i,
  input  logic [3:0] io_di_i,
  output logic       sck_rise_o,
  output logic       sck_fall_o,
  output logic       ce_rise_o,
  output logic       ce_fall_o,
  output logic [3:0] io_di_o
);

  // Stage [0],[1] synchronize; stage [2] is the history bit for edge detect.
  // All stages reset to 0 so a chip enable held low across reset never
  // looks like a fresh ce_n fall.
  logic [2:0] sck_q;
  logic [2:0] ce_q;
  logic [3:0] io1_q;
  logic [3:0] io2_q;

  // Synchronizer and edge-history shift chains.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= '0;
      ce_q  <= '0;
      io1_q <= '0;
      io2_q <= '0;
    end else begin
      sck_q <= {sck_q[1:0], sck_i};
      ce_q  <= {ce_q[1:0], ce_n_i};
      io1_q <= io_di_i;
      io2_q <= io1_q;
    end
  end

  assign sck_rise_o = sck_q[1] & ~sck_q[2];
  assign sck_fall_o = ~sck_q[1] & sck_q[2];
  assign ce_rise_o  = ce_q[1] & ~ce_q[2];
  assign ce_fall_o  = ~ce_q[1] & ce_q[2];
  assign io_di_o    = io2_q;

endmodule : psram_resp_sync
`default_nettype wire

// File: rtl/psram_qspi_responder.sv
`default_nettype none
// ============================================================================
// Module      : psram_qspi_responder
// Description : PSRAM-style SPI/QPI serial responder bridging a serial
//               controller onto a simple byte-wide memory port.
//               Commands: 0x03 read, 0x02 write, 0xEB quad read (with
//               dummy cycles), 0x38 quad write, 0x35/0xF5 enter/exit QPI.
//               Optional feature macro: PSRAM_RESP_QPI_EN enables QPI mode
//               and the 0x35/0xF5 commands; without it qpi_mode is tied 0.
//               MEM_AW must not exceed 24.
// Revision    : 1.0 - initial release
// ============================================================================
module psram_qspi_responder
  import psram_resp_pkg::*;
#(
  parameter int MEM_AW      = 16,
  parameter int WAIT_CYCLES = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              ce_n,
  input  logic [3:0]        io_di,
  output logic [3:0]        io_do,
  output logic [3:0]        io_oe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              qpi_mode
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

  logic       w_sck_rise, w_sck_fall, w_ce_rise, w_ce_fall;
  logic [3:0] w_io;

  psram_resp_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .sck_i      (sck),
    .ce_n_i     (ce_n),
    .io_di_i    (io_di),
    .sck_rise_o (w_sck_rise),
    .sck_fall_o (w_sck_fall),
    .ce_rise_o  (w_ce_rise),
    .ce_fall_o  (w_ce_fall),
    .io_di_o    (w_io)
  );

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;        // sck rises within the current phase
  logic [23:0]       sh_q, sh_d;          // shared cmd/addr/write-data shifter
  logic [7:0]        tx_q, tx_d;          // read byte being shifted out
  logic              wide_q, wide_d;      // data phase is 4 bits per sck
  logic              is_wr_q, is_wr_d;
  logic              is_eb_q, is_eb_d;
  logic              rd_valid_q, rd_valid_d;  // mem_rdata valid this cycle
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        io_do_q, io_do_d;
  logic [3:0]        io_oe_q, io_oe_d;
  logic              qpi_q;

`ifdef PSRAM_RESP_QPI_EN
  logic qpi_d;

  // QPI mode flag, changed only by the enter/exit commands.
  always_ff @(posedge clk) begin
    if (rst) qpi_q <= 1'b0;
    else     qpi_q <= qpi_d;
  end
`else
  assign qpi_q = 1'b0;
`endif

  // Command and address width follow the bus mode; write data width follows
  // the decoded command (quad commands always move nibbles).
  logic        w_wide;
  logic [23:0] w_sh;
  logic [7:0]  w_src;
  logic        w_unused_bits;

  assign w_wide = (state_q == WDATA) ? wide_q : qpi_q;
  assign w_sh   = w_wide ? {sh_q[19:0], w_io} : {sh_q[22:0], w_io[0]};
  // Freshly returned memory data bypasses tx_q so a fall in the same cycle
  // as the load still sends the new byte's first bits.
  assign w_src  = rd_valid_q ? mem_rdata : tx_q;
  assign w_unused_bits = ^{sh_q[23], w_sh};

  // Next-state and datapath decode; defaults first, ce_n rise has priority.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    tx_d        = tx_q;
    wide_d      = wide_q;
    is_wr_d     = is_wr_q;
    is_eb_d     = is_eb_q;
    rd_valid_d  = mem_re_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    mem_addr_d  = mem_addr_q;
    io_do_d     = io_do_q;
    io_oe_d     = io_oe_q;
`ifdef PSRAM_RESP_QPI_EN
    qpi_d       = qpi_q;
`endif

    // Address advances the cycle after each memory access (wraps naturally).
    if (mem_re_q || mem_we_q) mem_addr_d = mem_addr_q + MEM_AW'(1);
    if (rd_valid_q)           tx_d       = mem_rdata;

    if (w_ce_rise) begin
      state_d = IDLE;
      cnt_d   = '0;
      io_oe_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (w_ce_fall) begin
            state_d = CMD;
            cnt_d   = '0;
            sh_d    = '0;
          end
        end

        CMD: begin
          if (w_sck_rise) begin
            sh_d  = w_sh;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == (qpi_q ? 8'd1 : 8'd7)) begin
              cnt_d   = '0;
              is_wr_d = 1'b0;
              is_eb_d = 1'b0;
              wide_d  = qpi_q;
              case (w_sh[7:0])
                CMD_READ:   state_d = ADDR;
                CMD_WRITE: begin
                  state_d = ADDR;
                  is_wr_d = 1'b1;
                end
                CMD_QREAD: begin
                  state_d = ADDR;
                  is_eb_d = 1'b1;
                  wide_d  = 1'b1;
                end
                CMD_QWRITE: begin
                  state_d = ADDR;
                  is_wr_d = 1'b1;
                  wide_d  = 1'b1;
                end
`ifdef PSRAM_RESP_QPI_EN
                CMD_QPI_ENTER: begin
                  state_d = IDLE;
                  qpi_d   = 1'b1;
                end
                CMD_QPI_EXIT: begin
                  state_d = IDLE;
                  qpi_d   = 1'b0;
                end
`endif
                // Unknown opcode: park silently until ce_n rises.
                default:    state_d = IDLE;
              endcase
            end
          end
        end

        ADDR: begin
          if (w_sck_rise) begin
            sh_d  = w_sh;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == (qpi_q ? 8'd5 : 8'd23)) begin
              cnt_d      = '0;
              mem_addr_d = w_sh[MEM_AW-1:0];
              if (is_eb_q && (WAIT_CYCLES != 0)) begin
                state_d = WAIT;
              end else if (is_wr_q) begin
                state_d = WDATA;
              end else begin
                state_d  = RDATA;
                mem_re_d = 1'b1;
              end
            end
          end
        end

        WAIT: begin
          if (w_sck_rise) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == WAIT_LAST) begin
              cnt_d    = '0;
              state_d  = RDATA;
              mem_re_d = 1'b1;
            end
          end
        end

        RDATA: begin
          if (w_sck_fall) begin
            if (wide_q) begin
              io_oe_d = 4'hF;
              io_do_d = w_src[7:4];
              tx_d    = {w_src[3:0], 4'h0};
            end else begin
              io_oe_d = 4'b0010;
              io_do_d = {2'b00, w_src[7], 1'b0};
              tx_d    = {w_src[6:0], 1'b0};
            end
          end else if (w_sck_rise) begin
            cnt_d = cnt_q + 8'd1;
            // Final rise of a byte: fetch the next one ahead of the next fall.
            if (cnt_q == (wide_q ? 8'd1 : 8'd7)) begin
              cnt_d    = '0;
              mem_re_d = 1'b1;
            end
          end
        end

        WDATA: begin
          if (w_sck_rise) begin
            sh_d  = w_sh;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == (wide_q ? 8'd1 : 8'd7)) begin
              cnt_d       = '0;
              mem_we_d    = 1'b1;
              mem_wdata_d = w_sh[7:0];
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      tx_q        <= '0;
      wide_q      <= 1'b0;
      is_wr_q     <= 1'b0;
      is_eb_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
      io_do_q     <= '0;
      io_oe_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      tx_q        <= tx_d;
      wide_q      <= wide_d;
      is_wr_q     <= is_wr_d;
      is_eb_q     <= is_eb_d;
      rd_valid_q  <= rd_valid_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      mem_addr_q  <= mem_addr_d;
      io_do_q     <= io_do_d;
      io_oe_q     <= io_oe_d;
    end
  end

  assign io_do     = io_do_q;
  assign io_oe     = io_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign qpi_mode  = qpi_q;

endmodule : psram_qspi_responder
`default_nettype wire
